// File: rtl/mem_arb_pkg.sv
// Shared encodings for the external memory port arbiter.
// States, owner ids and the default data-burst limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int MAX_DATA_BURST_DEF = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data with a starvation counter.
// Data wins ties until it has won MAX_DATA_BURST times while fetch waits.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   idle,
  input  logic   if_req,
  input  logic   d_req,
  output logic   grant_valid,
  output owner_e grant_owner
);

  localparam logic [3:0] CMAX = 4'(MAX_DATA_BURST);

  logic [3:0] cnt_q;

  always_comb begin
    grant_valid = idle & (if_req | d_req);
    grant_owner = OWN_IF;
    if (d_req && (!if_req || cnt_q != CMAX))
      grant_owner = OWN_D;
  end

  // Counts data wins only while fetch is left waiting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (idle) begin
      if (!if_req || grant_owner == OWN_IF)
        cnt_q <= '0;
      else if (cnt_q != CMAX)
        cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and load/store.
// One transaction outstanding; fields latched on the winning cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                err_o
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q;
  arb_state_e        state_d;
  owner_e            owner_q;
  owner_e            grant_owner;
  logic              grant_valid;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              in_req;
  logic              in_wait;

  mem_arb_pick #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_pick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idle       (state_q == IDLE),
    .if_req     (if_req_i),
    .d_req      (d_req_i),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_rvalid_i && state_q != WAIT)
        err_q <= 1'b1;
      if (state_q == IDLE && grant_valid) begin
        owner_q <= grant_owner;
        if (grant_owner == OWN_D) begin
          we_q    <= d_we_i;
          be_q    <= d_be_i;
          addr_q  <= d_addr_i;
          wdata_q <= d_wdata_i;
        end else begin
          we_q    <= 1'b0;
          be_q    <= '1;
          addr_q  <= if_addr_i;
          wdata_q <= '0;
        end
      end
    end
  end

  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);

  assign mem_req_o   = in_req;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_gnt_o    = mem_gnt_i & in_req & (owner_q == OWN_IF);
  assign d_gnt_o     = mem_gnt_i & in_req & (owner_q == OWN_D);
  assign if_rvalid_o = mem_rvalid_i & in_wait & (owner_q == OWN_IF);
  assign d_rvalid_o  = mem_rvalid_i & in_wait & (owner_q == OWN_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
  assign err_o       = err_q;

endmodule
